// File: rtl/kcpsm6_io_pkg.sv
// Shared constants and helpers for the KCPSM6 port I/O bridge.
package kcpsm6_io_pkg;

  localparam logic [3:0] CTRL_SW_LEVEL = 4'd0;
  localparam logic [3:0] CTRL_EDGE     = 4'd1;
  localparam logic [3:0] CTRL_MASK     = 4'd2;

  localparam int unsigned SYNC_DEPTH = 2;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: synchroniser, stability counter, debounced level and rise pulse.
module sw_debounce
  import kcpsm6_io_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = clog2(DEB_CYCLES);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [CW-1:0]         cnt_q;

  // Level flips only after the synchronised value disagrees for DEB_CYCLES clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], raw};
      rise   <= 1'b0;
      if (sync_q[SYNC_DEPTH-1] != level) begin
        if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          level <= ~level;
          rise  <= ~level;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/kcpsm6_io_bridge.sv
// KCPSM6 port bus bridge: input mux, output registers, debounced switches,
// edge flags and a maskable interrupt with acknowledge.
module kcpsm6_io_bridge
  import kcpsm6_io_pkg::*;
#(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned NUM_OUT    = 2,
  parameter bit          ONEHOT_OUT = 1'b1,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter logic [7:0]  CTRL_BASE  = 8'hF0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           port_id,
  input  logic                 write_strobe,
  input  logic                 k_write_strobe,
  input  logic                 read_strobe,
  input  logic [7:0]           out_port,
  output logic [7:0]           in_port,
  output logic                 interrupt,
  input  logic                 interrupt_ack,
  input  logic [8*NUM_IN-1:0]  gpio_in,
  input  logic [7:0]           sw_raw,
  output logic [8*NUM_OUT-1:0] gpio_out
);

  logic [7:0]         sw_level;
  logic [7:0]         sw_rise;
  logic [7:0]         flags_q;
  logic [7:0]         mask_q;
  logic               ctrl_sel;
  logic [3:0]         ctrl_off;
  logic [7:0]         rd_data;
  logic [NUM_OUT-1:0] out_we;
  logic [7:0]         flag_clr;
  logic [7:0]         flags_next;
  logic               irq_set;
  logic               mask_we;

  for (genvar b = 0; b < 8; b++) begin : g_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_raw[b]),
      .level (sw_level[b]),
      .rise  (sw_rise[b])
    );
  end

  // Address decode, read mux, write enables and flag/interrupt next-state.
  always_comb begin
    ctrl_sel = (port_id[7:4] == CTRL_BASE[7:4]);
    ctrl_off = port_id[3:0];
    rd_data  = 8'h00;
    out_we   = '0;
    flag_clr = 8'h00;
    mask_we  = 1'b0;

    if (ctrl_sel) begin
      case (ctrl_off)
        CTRL_SW_LEVEL: rd_data = sw_level;
        CTRL_EDGE:     rd_data = flags_q;
        CTRL_MASK:     rd_data = mask_q;
        default:       rd_data = 8'h00;
      endcase
    end else begin
      for (int i = 0; i < int'(NUM_IN); i++) begin
        if (port_id == 8'(i)) rd_data = gpio_in[8*i +: 8];
      end
    end

    for (int i = 0; i < int'(NUM_OUT); i++) begin
      if (write_strobe && !ctrl_sel)
        out_we[i] = ONEHOT_OUT ? port_id[i] : (port_id == 8'(i));
      if (k_write_strobe && (port_id[3:0] == 4'(i)))
        out_we[i] = 1'b1;
    end

    if (ctrl_sel && ctrl_off == CTRL_EDGE) begin
      if (read_strobe)  flag_clr = 8'hFF;
      if (write_strobe) flag_clr = flag_clr | out_port;
    end
    if (ctrl_sel && ctrl_off == CTRL_MASK && write_strobe) mask_we = 1'b1;

    // A rise in the same cycle as a clear keeps the flag set.
    flags_next = (flags_q & ~flag_clr) | sw_rise;
    irq_set    = |(sw_rise & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_port   <= 8'h00;
      gpio_out  <= '0;
      flags_q   <= 8'h00;
      mask_q    <= 8'h00;
      interrupt <= 1'b0;
    end else begin
      in_port <= rd_data;
      for (int i = 0; i < int'(NUM_OUT); i++) begin
        if (out_we[i]) gpio_out[8*i +: 8] <= out_port;
      end
      flags_q <= flags_next;
      if (mask_we) mask_q <= out_port;
      interrupt <= irq_set | (interrupt & ~interrupt_ack);
    end
  end

endmodule
